// File: rtl/sync_down_counter.sv
// ---------------------------------------------------------------------------
// sync_down_counter
//   Synchronous, loadable N-bit down counter / timer. A load latches a start
//   value into the count and into a reload register. The count then
//   decrements on every enabled clock. A one-cycle terminal-count pulse is
//   produced on the edge that takes the count from 1 to 0. With auto-reload
//   set, the counter restarts from the reload register and keeps running.
//   This makes it a periodic tick generator.
//
//   Optional feature macro: SYNC_DOWN_CNT_STICKY_EN
//     When defined, the block adds a sticky terminal-count flag.
//     o_tc_sticky is set whenever tc is set and is cleared by i_tc_clr.
//     If set and clear happen in the same cycle, set wins.
//
// Ports
//   i_clk          in   1  clock, all state updates on the rising edge
//   i_rst          in   1  synchronous active-high reset (overrides all)
//   i_load         in   1  load strobe (priority over i_en)
//   i_load_val     in   N  start / reload value
//   i_en           in   1  count enable (used only while running)
//   i_auto_reload  in   1  1: reload at terminal count, 0: stop in DONE
//   i_tc_clr       in   1  sticky clear (only with SYNC_DOWN_CNT_STICKY_EN)
//   o_q            out  N  current count (registered)
//   o_tc           out  1  terminal-count pulse (registered, 1 cycle)
//   o_busy         out  1  high while in RUN
//   o_done         out  1  high while in DONE
//   o_tc_sticky    out  1  sticky tc flag (only with SYNC_DOWN_CNT_STICKY_EN)
// ---------------------------------------------------------------------------
module sync_down_counter #(
   parameter int N = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [N-1:0] i_load_val,
   input  logic         i_en,
   input  logic         i_auto_reload,
`ifdef SYNC_DOWN_CNT_STICKY_EN
   input  logic         i_tc_clr,
   output logic         o_tc_sticky,
`endif
   output logic [N-1:0] o_q,
   output logic         o_tc,
   output logic         o_busy,
   output logic         o_done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [N-1:0] ZERO = {N{1'b0}};
   localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

   state_t       r_state;
   logic [N-1:0] r_q;
   logic [N-1:0] r_reload;
   logic         r_tc;

   state_t       w_state_nxt;
   logic [N-1:0] w_q_nxt;
   logic [N-1:0] w_reload_nxt;
   logic         w_tc_nxt;

   // Next-state, next-count and terminal-count decode
   always_comb begin
      w_state_nxt  = r_state;
      w_q_nxt      = r_q;
      w_reload_nxt = r_reload;
      w_tc_nxt     = 1'b0;

      if (i_load) begin
         // A load never decrements. A zero load parks in IDLE without a pulse.
         w_q_nxt      = i_load_val;
         w_reload_nxt = i_load_val;
         if (i_load_val != ZERO) begin
            w_state_nxt = ST_RUN;
         end else begin
            w_state_nxt = ST_IDLE;
         end
      end else begin
         case (r_state)
            ST_RUN: begin
               if (i_en) begin
                  if (r_q > ONE) begin
                     w_q_nxt = r_q - ONE;
                  end else if (r_q == ONE) begin
                     w_tc_nxt = 1'b1;
                     if (i_auto_reload) begin
                        w_q_nxt     = r_reload;
                        w_state_nxt = ST_RUN;
                     end else begin
                        w_q_nxt     = ZERO;
                        w_state_nxt = ST_DONE;
                     end
                  end else begin
                     // Zero count while running is unreachable. Recover to
                     // IDLE rather than underflowing.
                     w_q_nxt     = ZERO;
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_q_nxt = r_q;
               end
            end
            ST_IDLE: begin
               w_q_nxt = r_q;
            end
            ST_DONE: begin
               w_q_nxt = r_q;
            end
            default: begin
               // Illegal state encoding: return to a safe idle.
               w_q_nxt     = ZERO;
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // State, count, reload and tc registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_q      <= ZERO;
         r_reload <= ZERO;
         r_tc     <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_q      <= w_q_nxt;
         r_reload <= w_reload_nxt;
         r_tc     <= w_tc_nxt;
      end
   end

`ifdef SYNC_DOWN_CNT_STICKY_EN
   logic r_tc_sticky;

   // Sticky terminal-count flag; a new tc beats a simultaneous clear
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tc_sticky <= 1'b0;
      end else if (w_tc_nxt) begin
         r_tc_sticky <= 1'b1;
      end else if (i_tc_clr) begin
         r_tc_sticky <= 1'b0;
      end else begin
         r_tc_sticky <= r_tc_sticky;
      end
   end

   assign o_tc_sticky = r_tc_sticky;
`endif

   assign o_q    = r_q;
   assign o_tc   = r_tc;
   assign o_busy = (r_state == ST_RUN);
   assign o_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_sync_down_counter.sv
// ---------------------------------------------------------------------------
// tb_sync_down_counter
//   Directed test of sync_down_counter with N=4. Inputs change 1 time unit
//   after each rising edge. Outputs are checked at that same point, so they
//   are never sampled on the active edge.
// ---------------------------------------------------------------------------
module tb_sync_down_counter;

   localparam int N = 4;

   logic         clk;
   logic         rst;
   logic         load;
   logic [N-1:0] load_val;
   logic         en;
   logic         auto_reload;
   logic [N-1:0] q;
   logic         tc;
   logic         busy;
   logic         done;
`ifdef SYNC_DOWN_CNT_STICKY_EN
   logic         tc_clr;
   logic         tc_sticky;
`endif

   int n_total;
   int n_bad;
   int tc_count;
   int exp_q;

   sync_down_counter #(.N(N)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_load        (load),
      .i_load_val    (load_val),
      .i_en          (en),
      .i_auto_reload (auto_reload),
`ifdef SYNC_DOWN_CNT_STICKY_EN
      .i_tc_clr      (tc_clr),
      .o_tc_sticky   (tc_sticky),
`endif
      .o_q           (q),
      .o_tc          (tc),
      .o_busy        (busy),
      .o_done        (done)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run can never hang
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_total = n_total + 1;
      if (obs !== exp_v) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input int eq, input logic etc,
                            input logic ebusy, input logic edone);
      check_val({tag, ".q"},    32'(q),    32'(eq));
      check_val({tag, ".tc"},   32'(tc),   32'(etc));
      check_val({tag, ".busy"}, 32'(busy), 32'(ebusy));
      check_val({tag, ".done"}, 32'(done), 32'(edone));
   endtask

   initial begin
      n_total     = 0;
      n_bad       = 0;
      rst         = 1'b1;
      load        = 1'b1;
      load_val    = 4'd9;
      en          = 1'b1;
      auto_reload = 1'b0;
`ifdef SYNC_DOWN_CNT_STICKY_EN
      tc_clr      = 1'b0;
`endif

      // Reset beats a simultaneous load
      step();
      check_all("reset1", 0, 1'b0, 1'b0, 1'b0);
      step();
      check_all("reset2", 0, 1'b0, 1'b0, 1'b0);
      rst  = 1'b0;
      load = 1'b0;
      en   = 1'b0;
      step();
      check_all("idle", 0, 1'b0, 1'b0, 1'b0);

      // One-shot from 5
      load = 1'b1; load_val = 4'd5; en = 1'b1; auto_reload = 1'b0;
      step();
      check_all("os_load", 5, 1'b0, 1'b1, 1'b0);
      load = 1'b0;
      for (int i = 4; i >= 0; i--) begin
         step();
         check_all("os_cnt", i, (i == 0), (i != 0), (i == 0));
      end
      for (int i = 0; i < 10; i++) begin
         step();
         check_all("os_hold", 0, 1'b0, 1'b0, 1'b1);
      end

      // Auto-reload with period 3
      load = 1'b1; load_val = 4'd3; auto_reload = 1'b1; en = 1'b1;
      step();
      check_all("ar_load", 3, 1'b0, 1'b1, 1'b0);
      load     = 1'b0;
      tc_count = 0;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (tc) tc_count++;
         check_all("ar_cnt", ((k % 3) == 0) ? 3 : 3 - (k % 3), ((k % 3) == 0), 1'b1, 1'b0);
      end
      check_val("ar_pulses", 32'(tc_count), 32'd4);

      // Pause: en alternates, the count moves only on enabled edges
      auto_reload = 1'b0;
      load = 1'b1; load_val = 4'd4; en = 1'b0;
      step();
      check_all("pz_load", 4, 1'b0, 1'b1, 1'b0);
      load  = 1'b0;
      exp_q = 4;
      for (int k = 1; k <= 6; k++) begin
         en = (k % 2) == 1;
         if (en) exp_q--;
         step();
         check_all("pz_cnt", exp_q, 1'b0, 1'b1, 1'b0);
      end
      // Load has priority over en
      load = 1'b1; load_val = 4'd7; en = 1'b1;
      step();
      check_all("pz_ld7", 7, 1'b0, 1'b1, 1'b0);
      // Zero load parks in IDLE without tc
      load_val = 4'd0;
      step();
      check_all("pz_ld0", 0, 1'b0, 1'b0, 1'b0);
      load = 1'b0;
      step();
      check_all("pz_idle", 0, 1'b0, 1'b0, 1'b0);

      // Full-scale load: 15 enabled cycles to tc, no wrap
      load = 1'b1; load_val = 4'd15; en = 1'b1; auto_reload = 1'b0;
      step();
      check_all("fs_load", 15, 1'b0, 1'b1, 1'b0);
      load = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         step();
         check_all("fs_cnt", 15 - k, (k == 15), (k != 15), (k == 15));
      end
      step();
      check_all("fs_nowrap", 0, 1'b0, 1'b0, 1'b1);

      // Reload value 1: tc follows en every cycle
      load = 1'b1; load_val = 4'd1; auto_reload = 1'b1; en = 1'b0;
      step();
      check_all("r1_load", 1, 1'b0, 1'b1, 1'b0);
      load = 1'b0;
      for (int k = 0; k < 5; k++) begin
         en = (k != 2);
         step();
         check_all("r1_cnt", 1, en, 1'b1, 1'b0);
      end

      // Reset in mid-count aborts without tc
      load = 1'b1; load_val = 4'd12; auto_reload = 1'b0; en = 1'b1;
      step();
      load = 1'b0;
      for (int k = 0; k < 4; k++) step();
      check_all("rm_at8", 8, 1'b0, 1'b1, 1'b0);
      rst = 1'b1;
      step();
      check_all("rm_rst", 0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check_all("rm_after", 0, 1'b0, 1'b0, 1'b0);
      end

`ifdef SYNC_DOWN_CNT_STICKY_EN
      check_val("st_rst", 32'(tc_sticky), 32'd0);
      load = 1'b1; load_val = 4'd1; auto_reload = 1'b1; en = 1'b0;
      step();
      load = 1'b0;
      check_val("st_pre", 32'(tc_sticky), 32'd0);
      en = 1'b1;
      step();
      check_val("st_tc", 32'(tc), 32'd1);
      check_val("st_set", 32'(tc_sticky), 32'd1);
      en = 1'b0;
      step();
      check_val("st_hold", 32'(tc_sticky), 32'd1);
      tc_clr = 1'b1; en = 1'b1;
      step();
      check_val("st_clr_tc", 32'(tc), 32'd1);
      check_val("st_setwins", 32'(tc_sticky), 32'd1);
      en = 1'b0;
      step();
      check_val("st_clr", 32'(tc_sticky), 32'd0);
      tc_clr = 1'b0;
      step();
      check_val("st_stay0", 32'(tc_sticky), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
